// File: rtl/pc_decode_alu_pkg.sv
// Shared constants for pc_decode_alu: ALU op encoding, opcodes and funct7 values.
// Optional feature macro used elsewhere: PC_DECODE_ALU_HALT_EN.
package pc_decode_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/pc_decode_alu_if.sv
// Datapath bus between the fetch/regfile side (master) and pc_decode_alu (slave).
// The halt signal exists only when PC_DECODE_ALU_HALT_EN is defined.
interface pc_decode_alu_if;
  logic        pc_en;
  logic [31:0] instruction;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;
  logic        reg_write;
  logic        illegal;
`ifdef PC_DECODE_ALU_HALT_EN
  logic        halt;
`endif

  // No handshake: inputs are sampled every cycle, outputs are valid whenever inputs are stable.
  modport master (
    output pc_en, instruction, rs1_data, rs2_data,
    input  pc, pc_next, rs1, rs2, rd, alu_control, alu_result, zero, reg_write, illegal
`ifdef PC_DECODE_ALU_HALT_EN
    , input halt
`endif
  );

  modport slave (
    input  pc_en, instruction, rs1_data, rs2_data,
    output pc, pc_next, rs1, rs2, rd, alu_control, alu_result, zero, reg_write, illegal
`ifdef PC_DECODE_ALU_HALT_EN
    , output halt
`endif
  );
endinterface

// File: rtl/pc_decode_alu_exec_alu.sv
// Combinational 32-bit ALU: add/sub/logic/logical shifts/signed compare plus zero flag.
module exec_alu
  import pc_decode_alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     alu_control_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = 32'h0;
    case (alu_control_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_SRL: result_o = a_i >> b_i[4:0];
      ALU_SLT: result_o = {31'h0, ($signed(a_i) < $signed(b_i))};
      default: result_o = 32'h0;
    endcase
  end

  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/pc_decode_alu.sv
// Single-cycle RV32 front half: PC register, R/I-type ALU decoder and ALU.
// Define PC_DECODE_ALU_HALT_EN to add ECALL/EBREAK sticky halt.
module pc_decode_alu
  import pc_decode_alu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  pc_decode_alu_if.slave   bus
);

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, op_b;
  alu_op_e     alu_op;
  logic        legal, writes_rd, sys_halt;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign funct7 = bus.instruction[31:25];
  assign imm_i  = {{20{bus.instruction[31]}}, bus.instruction[31:20]};

  always_comb begin
    alu_op    = ALU_ADD;
    op_b      = bus.rs2_data;
    legal     = 1'b0;
    writes_rd = 1'b1;
    sys_halt  = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     begin alu_op = ALU_ADD; legal = 1'b1; end
            else if (funct7 == F7_ALT) begin alu_op = ALU_SUB; legal = 1'b1; end
          end
          3'b111: begin alu_op = ALU_AND; legal = (funct7 == F7_BASE); end
          3'b110: begin alu_op = ALU_OR;  legal = (funct7 == F7_BASE); end
          3'b100: begin alu_op = ALU_XOR; legal = (funct7 == F7_BASE); end
          3'b001: begin alu_op = ALU_SLL; legal = (funct7 == F7_BASE); end
          3'b101: begin alu_op = ALU_SRL; legal = (funct7 == F7_BASE); end
          3'b010: begin alu_op = ALU_SLT; legal = (funct7 == F7_BASE); end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = 1'b1;
        op_b  = imm_i;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b111: alu_op = ALU_AND;
          3'b110: alu_op = ALU_OR;
          3'b100: alu_op = ALU_XOR;
          3'b010: alu_op = ALU_SLT;
          3'b001: begin alu_op = ALU_SLL; op_b = {27'h0, bus.instruction[24:20]}; legal = (funct7 == F7_BASE); end
          3'b101: begin alu_op = ALU_SRL; op_b = {27'h0, bus.instruction[24:20]}; legal = (funct7 == F7_BASE); end
          default: legal = 1'b0;
        endcase
      end
`ifdef PC_DECODE_ALU_HALT_EN
      OPC_SYSTEM: begin
        if (bus.instruction == INSN_ECALL || bus.instruction == INSN_EBREAK) begin
          legal     = 1'b1;
          writes_rd = 1'b0;
          sys_halt  = 1'b1;
        end
      end
`endif
      default: legal = 1'b0;
    endcase
    // Illegal encodings fall back to rs1 + rs2 so the ALU output is still well defined.
    if (!legal) begin
      alu_op = ALU_ADD;
      op_b   = bus.rs2_data;
    end
  end

  exec_alu u_exec_alu (
    .a_i           (bus.rs1_data),
    .b_i           (op_b),
    .alu_control_i (alu_op),
    .result_o      (bus.alu_result),
    .zero_o        (bus.zero)
  );

  assign bus.rs1         = bus.instruction[19:15];
  assign bus.rs2         = bus.instruction[24:20];
  assign bus.rd          = bus.instruction[11:7];
  assign bus.alu_control = alu_op;
  assign bus.illegal     = !legal;
  assign bus.reg_write   = legal && writes_rd && (bus.instruction[11:7] != 5'd0);
  assign bus.pc_next     = pc_q + PC_STEP;
  assign bus.pc          = pc_q;

`ifdef PC_DECODE_ALU_HALT_EN
  logic halted_q, halted_d;
  assign halted_d = halted_q | sys_halt;
  assign pc_d     = (bus.pc_en && !halted_q) ? bus.pc_next : pc_q;
  assign bus.halt = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end
`else
  logic unused_sys_halt;
  assign unused_sys_halt = sys_halt;
  assign pc_d = bus.pc_en ? bus.pc_next : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end
`endif

endmodule

// File: tb/tb_pc_decode_alu.sv
// Directed self-checking bench for pc_decode_alu (default build and PC_DECODE_ALU_HALT_EN).
module tb_pc_decode_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_decode_alu_if bus ();
  pc_decode_alu_if bus_w ();

  pc_decode_alu dut (.clk(clk), .rst(rst), .bus(bus));
  pc_decode_alu #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    bus.instruction = insn;
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    #1;
  endtask

  initial begin
    bus.pc_en = 1'b0;
    bus.instruction = 32'h0;
    bus.rs1_data = 32'h0;
    bus.rs2_data = 32'h0;
    bus_w.pc_en = 1'b0;
    bus_w.instruction = 32'h0000_0013;
    bus_w.rs1_data = 32'h0;
    bus_w.rs2_data = 32'h0;
    #2;
    check("reset_pc", bus.pc, 32'h0);
    check("reset_pc_next", bus.pc_next, 32'h4);

    // Advance to pc = 0x10, then pulse reset between edges.
    tick();
    rst = 1'b0;
    bus.pc_en = 1'b1;
    tick(); tick(); tick(); tick();
    check("pc_run_0x10", bus.pc, 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_pc", bus.pc, 32'h0);
    check("async_reset_pc_next", bus.pc_next, 32'h4);
    tick();
    check("reset_held_pc", bus.pc, 32'h0);
    rst = 1'b0;
    #1;
    check("release_pc0", bus.pc, 32'h0);
    tick();
    check("release_pc4", bus.pc, 32'h4);
    tick();
    check("release_pc8", bus.pc, 32'h8);

    // Wrap instance stays stalled, then wraps to 0.
    check("wrap_pc", bus_w.pc, 32'hFFFF_FFFC);
    check("wrap_pc_next", bus_w.pc_next, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus_w.pc, 32'hFFFF_FFFC);
    end
    bus_w.pc_en = 1'b1;
    tick();
    check("wrap_pc_after", bus_w.pc, 32'h0);

    // add x3,x1,x2
    drive(32'h0020_81B3, 32'd5, 32'd7);
    check("add_rs1", {27'h0, bus.rs1}, 32'd1);
    check("add_rs2", {27'h0, bus.rs2}, 32'd2);
    check("add_rd", {27'h0, bus.rd}, 32'd3);
    check("add_ctrl", {29'h0, bus.alu_control}, 32'd0);
    check("add_result", bus.alu_result, 32'd12);
    check("add_zero", {31'h0, bus.zero}, 32'd0);
    check("add_rw", {31'h0, bus.reg_write}, 32'd1);
    check("add_illegal", {31'h0, bus.illegal}, 32'd0);

    // sub x3,x1,x2 with equal operands
    drive(32'h4020_81B3, 32'd9, 32'd9);
    check("sub_ctrl", {29'h0, bus.alu_control}, 32'd1);
    check("sub_result", bus.alu_result, 32'd0);
    check("sub_zero", {31'h0, bus.zero}, 32'd1);

    // slti x5,x1,-1 with a = most negative
    drive(32'hFFF0_A293, 32'h8000_0000, 32'h0);
    check("slti_ctrl", {29'h0, bus.alu_control}, 32'd7);
    check("slti_result", bus.alu_result, 32'd1);
    check("slti_rd", {27'h0, bus.rd}, 32'd5);

    // srli x5,x1,4
    drive(32'h0040_D293, 32'hF000_0000, 32'h0);
    check("srli_ctrl", {29'h0, bus.alu_control}, 32'd6);
    check("srli_result", bus.alu_result, 32'h0F00_0000);

    // and / sll / slt register forms
    drive(32'h0020_F1B3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("and_result", bus.alu_result, 32'hF000_F000);
    drive(32'h0020_91B3, 32'd1, 32'h23);
    check("sll_result", bus.alu_result, 32'd8);
    drive(32'h0020_A1B3, 32'hFFFF_FFFB, 32'd3);
    check("slt_result", bus.alu_result, 32'd1);

    // srai is unsupported: falls back to rs1 + rs2
    drive(32'h4040_D293, 32'd10, 32'd20);
    check("srai_illegal", {31'h0, bus.illegal}, 32'd1);
    check("srai_result", bus.alu_result, 32'd30);

    // all-zero word is illegal
    drive(32'h0000_0000, 32'd5, 32'd7);
    check("zero_illegal", {31'h0, bus.illegal}, 32'd1);
    check("zero_rw", {31'h0, bus.reg_write}, 32'd0);
    check("zero_ctrl", {29'h0, bus.alu_control}, 32'd0);
    check("zero_result", bus.alu_result, 32'd12);

    // add x0,x1,x2 is legal but does not write
    drive(32'h0020_8033, 32'd1, 32'd2);
    check("rd0_illegal", {31'h0, bus.illegal}, 32'd0);
    check("rd0_rw", {31'h0, bus.reg_write}, 32'd0);

`ifdef PC_DECODE_ALU_HALT_EN
    drive(32'h0000_0073, 32'd0, 32'd0);
    check("ecall_illegal", {31'h0, bus.illegal}, 32'd0);
    check("ecall_rw", {31'h0, bus.reg_write}, 32'd0);
    check("pre_halt", {31'h0, bus.halt}, 32'd0);
    tick();
    check("halt_set", {31'h0, bus.halt}, 32'd1);
    bus.instruction = 32'h0020_81B3;
    begin
      logic [31:0] frozen_pc;
      frozen_pc = bus.pc;
      tick();
      check("halt_frozen_pc", bus.pc, frozen_pc);
      tick();
      check("halt_frozen_pc2", bus.pc, frozen_pc);
    end
    check("halt_sticky", {31'h0, bus.halt}, 32'd1);
`else
    drive(32'h0000_0073, 32'd0, 32'd0);
    check("ecall_illegal", {31'h0, bus.illegal}, 32'd1);
    check("ecall_rw", {31'h0, bus.reg_write}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_decode_alu.md
Name: pc_decode_alu

Overview:
- Front half of the single-cycle RV32 integer datapath: PC register with +4 incrementer, instruction decoder and 32-bit ALU.
- Takes the fetched instruction and register-file read data.
- Produces register addresses, ALU control, ALU result and zero flag, write-enable and next PC.
- The register file and instruction memory sit outside this block.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment added to PC each enabled cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_en  input  1  PC advances on the rising clk edge when 1; PC holds when 0.
- instruction  input  32  instruction at the current PC.
- rs1_data  input  32  register-file value for rs1.
- rs2_data  input  32  register-file value for rs2.
- pc  output  32  current PC (registered).
- pc_next  output  32  pc + PC_STEP (combinational).
- rs1  output  5  instruction[19:15].
- rs2  output  5  instruction[24:20].
- rd  output  5  instruction[11:7].
- alu_control  output  3  decoded ALU operation.
- alu_result  output  32  ALU output.
- zero  output  1  1 when alu_result == 0.
- reg_write  output  1  1 when rd is written with alu_result.
- illegal  output  1  1 for an unsupported encoding.

Behaviour:
- Reset and clocking: clk single clock domain; rst asynchronous, active-high.
- On rst, pc = RESET_PC immediately, without waiting for a clock edge. All other outputs are combinational and follow the inputs (pc_next = RESET_PC+PC_STEP during reset).
- PC update: on a rising clk edge with rst low and pc_en = 1, pc <= pc_next.
- pc_next arithmetic is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Register-field outputs: rs1, rs2, rd are pure bit slices, driven for every instruction.
- alu_control encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT (signed).
- R-type (opcode 7'b0110011), operands a = rs1_data, b = rs2_data:
  - funct3 000 with funct7 0000000 -> ADD; with funct7 0100000 -> SUB.
  - funct3 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL, 010 SLT, all requiring funct7 0000000.
  - Any other funct7/funct3 combination is illegal.
- I-type (opcode 7'b0010011), operands a = rs1_data, b = sign-extended instruction[31:20]:
  - funct3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT.
  - funct3 001 SLL and 101 SRL require instruction[31:25] = 0000000; b = shamt (instruction[24:20]).
  - SUB does not exist in I-type; funct3 011 and SRAI are illegal.
- Shift amount is b[4:0]; SRL is a logical shift.
- SLT result is 32'h1 if $signed(a) < $signed(b), else 32'h0.
- ADD/SUB wrap modulo 2^32; no overflow flag.
- Legal decode: reg_write = 1 and illegal = 0, except rd == 0 forces reg_write = 0.
- Illegal decode (any other opcode, or an illegal funct combination): alu_control = ADD, b = rs2_data, reg_write = 0, illegal = 1. PC still advances normally.
- Latency: decode, ALU and pc_next are zero-latency combinational; only pc is registered (one cycle).
- Reset mid-run: pc snaps to RESET_PC asynchronously; the first enabled edge after rst deasserts loads RESET_PC+PC_STEP.

Optional Feature:
- Macro PC_DECODE_ALU_HALT_EN adds output halt (1 bit).
- With the macro defined:
  - instruction == 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK) sets a sticky halted flag on the next rising edge.
  - While the halted flag is set, pc is frozen regardless of pc_en, and halt = 1.
  - These two encodings decode as legal with reg_write = 0.
  - rst clears the halted flag.
- Without the macro: no halt port; opcode 7'b1110011 decodes as illegal.

Decomposition:
- Package pc_decode_alu_pkg holds:
  - ALU op localparams/enum (ALU_ADD..ALU_SLT).
  - Opcode constants OPC_OP = 7'b0110011, OPC_OP_IMM = 7'b0010011, OPC_SYSTEM = 7'b1110011.
  - funct7 constants F7_BASE = 7'b0000000, F7_ALT = 7'b0100000.
- One natural sub-module: exec_alu (a, b, alu_control -> result, zero), purely combinational.
- Decoder and PC register stay inline.

Test Plan:
- Reset: assert rst mid-cycle at pc = 32'h10 -> pc = 32'h0 immediately. Release rst, hold pc_en = 1 -> pc goes 0, 4, 8 on successive edges.
- Wrap and stall: force pc to 32'hFFFF_FFFC -> pc_next = 0. With pc_en = 0 for 3 edges, pc holds.
- add x3,x1,x2 (32'h002081B3), rs1_data = 5, rs2_data = 7 -> rs1 = 1, rs2 = 2, rd = 3, alu_control = 000, alu_result = 12, zero = 0, reg_write = 1.
- sub x3,x1,x2 (32'h402081B3), both operands 9 -> alu_result = 0, zero = 1.
- slti x5,x1,-1 (32'hFFF0A293), rs1_data = 32'h8000_0000 -> alu_result = 1. srli x5,x1,4 with rs1_data = 32'hF000_0000 -> 32'h0F00_0000.
- Illegal/rd0: 32'h0000_0000 -> illegal = 1, reg_write = 0. add x0,x1,x2 -> reg_write = 0. With PC_DECODE_ALU_HALT_EN, 32'h0000_0073 -> halt = 1 and pc frozen from the next edge.
